// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// default parameter values and the load-use match function.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MDU_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } state_e;

  localparam int DEF_REG_ADDR_W        = 5;
  localparam int DEF_LOAD_STALL_CYCLES = 1;
  localparam int DEF_FLUSH_CYCLES      = 1;
  localparam int DEF_CNT_W             = 3;
  localparam int DEF_PERF_W            = 32;

  // Register addresses are zero-extended to this width before comparison.
  localparam int LU_ADDR_W = 16;

  // Load-use hit: EX load writes a non-zero register that ID actually reads.
  function automatic logic lu_hit_f(
    input logic                 memread_ex,
    input logic [LU_ADDR_W-1:0] wr_addr_ex,
    input logic [LU_ADDR_W-1:0] rs_addr,
    input logic [LU_ADDR_W-1:0] rt_addr,
    input logic                 rs_used,
    input logic                 rt_used
  );
    logic rs_match;
    logic rt_match;
    rs_match = rs_used && (wr_addr_ex == rs_addr);
    rt_match = rt_used && (wr_addr_ex == rt_addr);
    return memread_ex && (wr_addr_ex != {LU_ADDR_W{1'b0}}) && (rs_match || rt_match);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= {W{1'b0}};
    end else if (clr) begin
      r_q <= {W{1'b0}};
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller beside ID: load-use and MDU interlocks, redirect flush
// windows, and stall/flush cycle counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = DEF_REG_ADDR_W,
  parameter int LOAD_STALL_CYCLES = DEF_LOAD_STALL_CYCLES,
  parameter int FLUSH_CYCLES      = DEF_FLUSH_CYCLES,
  parameter int CNT_W             = DEF_CNT_W,
  parameter int PERF_W            = DEF_PERF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs_addr_id,
  input  logic [REG_ADDR_W-1:0] rt_addr_id,
  input  logic                  rs_used_id,
  input  logic                  rt_used_id,
  input  logic                  memread_ex,
  input  logic [REG_ADDR_W-1:0] regwrite_addr_ex,
  input  logic                  mdu_use_id,
  input  logic                  mdu_busy,
  input  logic                  branch_taken,
  input  logic                  jump,
  input  logic                  perf_clr,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            state_o,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_cycles
);

  if ((LOAD_STALL_CYCLES < 1) || (LOAD_STALL_CYCLES > 7)) begin : g_bad_lsc
    $fatal(1, "hazard_ctrl_unit: LOAD_STALL_CYCLES must be 1..7");
  end
  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 3)) begin : g_bad_fc
    $fatal(1, "hazard_ctrl_unit: FLUSH_CYCLES must be 1..3");
  end
  if ((CNT_W < 3) || (REG_ADDR_W < 1) || (REG_ADDR_W > LU_ADDR_W) || (PERF_W < 1)) begin : g_bad_w
    $fatal(1, "hazard_ctrl_unit: illegal width parameter");
  end

  // Counter preloads: the cycle spent in IDLE already counts as the first one.
  localparam logic [CNT_W-1:0] LS_LOAD =
    CNT_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] FL_LOAD =
    CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_lu_hit;
  logic             w_mdu_hit;
  logic             w_redirect;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_stall;
  logic             w_flush;

  assign w_lu_hit   = lu_hit_f(memread_ex, LU_ADDR_W'(regwrite_addr_ex),
                               LU_ADDR_W'(rs_addr_id), LU_ADDR_W'(rt_addr_id),
                               rs_used_id, rt_used_id);
  assign w_mdu_hit  = mdu_use_id && mdu_busy;
  assign w_redirect = branch_taken || jump;

  // State and sequencing counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and control outputs; IDLE priority is load-use, MDU, redirect.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_lu_hit) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_stall      = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_state_nxt = ST_LOAD_STALL;
            w_cnt_nxt   = LS_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_mdu_hit) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_stall      = 1'b1;
          w_state_nxt  = ST_MDU_WAIT;
        end else if (w_redirect) begin
          w_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = FL_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD_STALL: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_stall      = 1'b1;
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_MDU_WAIT: begin
        // Release happens in the same cycle busy drops; redirects wait for re-presentation.
        if (mdu_busy) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_stall      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign pc_write   = w_pc_write;
  assign ifid_write = w_ifid_write;
  assign stall      = w_stall;
  assign flush      = w_flush;
  assign state_o    = r_state;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (w_stall),
    .q   (stall_cycles)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (w_flush),
    .q   (flush_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: instance A (1 load bubble, 2 flush cycles, 32-bit counters)
// and instance B (3 load bubbles, 1 flush cycle, 3-bit counters for saturation).
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs_addr_id = 5'd0, rt_addr_id = 5'd0, regwrite_addr_ex = 5'd0;
  logic       rs_used_id = 1'b0, rt_used_id = 1'b0, memread_ex = 1'b0;
  logic       mdu_use_id = 1'b0, mdu_busy = 1'b0;
  logic       branch_taken = 1'b0, jump = 1'b0, perf_clr = 1'b0;

  logic        a_pc_write, a_ifid_write, a_stall, a_flush;
  logic [1:0]  a_state;
  logic [31:0] a_stall_cycles, a_flush_cycles;
  logic        b_pc_write, b_ifid_write, b_stall, b_flush;
  logic [1:0]  b_state;
  logic [2:0]  b_stall_cycles, b_flush_cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2),
                     .CNT_W(3), .PERF_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .memread_ex(memread_ex),
    .regwrite_addr_ex(regwrite_addr_ex), .mdu_use_id(mdu_use_id), .mdu_busy(mdu_busy),
    .branch_taken(branch_taken), .jump(jump), .perf_clr(perf_clr),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .stall(a_stall), .flush(a_flush),
    .state_o(a_state), .stall_cycles(a_stall_cycles), .flush_cycles(a_flush_cycles)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(1),
                     .CNT_W(3), .PERF_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
    .rs_used_id(rs_used_id), .rt_used_id(rt_used_id), .memread_ex(memread_ex),
    .regwrite_addr_ex(regwrite_addr_ex), .mdu_use_id(mdu_use_id), .mdu_busy(mdu_busy),
    .branch_taken(branch_taken), .jump(jump), .perf_clr(perf_clr),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .stall(b_stall), .flush(b_flush),
    .state_o(b_state), .stall_cycles(b_stall_cycles), .flush_cycles(b_flush_cycles)
  );

  typedef struct {
    logic       mr;
    logic [4:0] wa, rs, rt;
    logic       rsu, rtu, mu, mb, br, jp;
    logic       pcw, ifw, stl, fl;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    string      tag;
    logic       is_b;
    logic       pcw, ifw, stl, fl;
    logic [1:0] st;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int mr, wa, rs, rt, rsu, rtu, mu, mb, br, jp,
                     input int pcw, ifw, stl, fl, st);
    vec_t v;
    v.mr = 1'(mr); v.wa = 5'(wa); v.rs = 5'(rs); v.rt = 5'(rt);
    v.rsu = 1'(rsu); v.rtu = 1'(rtu); v.mu = 1'(mu); v.mb = 1'(mb);
    v.br = 1'(br); v.jp = 1'(jp);
    v.pcw = 1'(pcw); v.ifw = 1'(ifw); v.stl = 1'(stl); v.fl = 1'(fl); v.st = 2'(st);
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare at the falling edge.
  task automatic step(input string tag, input logic is_b, input vec_t v);
    exp_t e;
    exp_t got;
    memread_ex = v.mr; regwrite_addr_ex = v.wa; rs_addr_id = v.rs; rt_addr_id = v.rt;
    rs_used_id = v.rsu; rt_used_id = v.rtu; mdu_use_id = v.mu; mdu_busy = v.mb;
    branch_taken = v.br; jump = v.jp;
    e.tag = tag; e.is_b = is_b; e.pcw = v.pcw; e.ifw = v.ifw; e.stl = v.stl;
    e.fl = v.fl; e.st = v.st;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    if (got.is_b) begin
      check({got.tag, ".pc_write"},   b_pc_write,   got.pcw);
      check({got.tag, ".ifid_write"}, b_ifid_write, got.ifw);
      check({got.tag, ".stall"},      b_stall,      got.stl);
      check({got.tag, ".flush"},      b_flush,      got.fl);
      check({got.tag, ".state"},      b_state,      got.st);
    end else begin
      check({got.tag, ".pc_write"},   a_pc_write,   got.pcw);
      check({got.tag, ".ifid_write"}, a_ifid_write, got.ifw);
      check({got.tag, ".stall"},      a_stall,      got.stl);
      check({got.tag, ".flush"},      a_flush,      got.fl);
      check({got.tag, ".state"},      a_state,      got.st);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int mr, wa, rs, rt, rsu, rtu, mu, mb, br, jp,
                              input int pcw, ifw, stl, fl, st);
    vec_t v;
    v.mr = 1'(mr); v.wa = 5'(wa); v.rs = 5'(rs); v.rt = 5'(rt);
    v.rsu = 1'(rsu); v.rtu = 1'(rtu); v.mu = 1'(mu); v.mb = 1'(mb);
    v.br = 1'(br); v.jp = 1'(jp);
    v.pcw = 1'(pcw); v.ifw = 1'(ifw); v.stl = 1'(stl); v.fl = 1'(fl); v.st = 2'(st);
    return v;
  endfunction

  initial begin
    int exp_stall;
    int exp_flush;
    vec_t idle_v;
    idle_v = mk(0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0);

    // Instance A table:   mr wa rs rt rsu rtu mu mb br jp | pcw ifw stl fl st
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0); // idle
    add(1, 8, 8, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0); // lw $8, rs=8
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0); // single bubble only
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0); // $0 never hazards
    add(1, 9, 0, 9, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0); // rt match, rt unused
    add(1, 9, 0, 9, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0); // rt match, rt used
    add(1, 7, 7, 0, 1, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0); // lu beats branch+jump
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0); // jump: flush 1
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 3); // flush 2
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 0); // jump again
    add(1, 5, 5, 0, 1, 0, 1, 1, 0, 0,  1, 1, 0, 1, 3); // hazards ignored in FLUSH
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 0, 0); // MDU busy 1
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 0, 2); // 2
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 1, 0, 2); // 3, branch ignored
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 0, 2); // 4
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 0, 2); // 5
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 2); // release as busy falls
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0); // busy but not used
    add(1, 4, 0, 4, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0, 0); // lu beats mdu
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0); // so no MDU_WAIT
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 1, 0); // branch flush 1
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 3); // flush 2
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);

    // Reset values, both instances.
    #2;
    check("rst.a_pc_write", a_pc_write, 1); check("rst.a_ifid_write", a_ifid_write, 1);
    check("rst.a_stall", a_stall, 0);       check("rst.a_flush", a_flush, 0);
    check("rst.a_state", a_state, 0);       check("rst.a_stall_cycles", a_stall_cycles, 0);
    check("rst.b_stall", b_stall, 0);       check("rst.b_flush_cycles", b_flush_cycles, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    exp_stall = 0;
    exp_flush = 0;
    foreach (vecs[i]) begin
      step($sformatf("vecA%0d", i), 1'b0, vecs[i]);
      exp_stall += int'(vecs[i].stl);
      exp_flush += int'(vecs[i].fl);
    end
    check("a.stall_cycles", a_stall_cycles, exp_stall);
    check("a.flush_cycles", a_flush_cycles, exp_flush);

    // Resynchronise B, then a 3-cycle load stall with memread dropped after cycle 1.
    rst = 1'b1; #2; rst = 1'b0;
    step("b_ls1", 1'b1, mk(1,8,8,0,1,0,0,0,0,0, 0,0,1,0,0));
    step("b_ls2", 1'b1, mk(0,0,0,0,0,0,0,0,0,0, 0,0,1,0,1));
    step("b_ls3", 1'b1, mk(0,0,0,0,0,0,0,0,0,0, 0,0,1,0,1));
    step("b_ls4", 1'b1, idle_v);
    check("b.stall_cycles_3", b_stall_cycles, 3);

    // Reset in the 2nd cycle of a 3-cycle load stall.
    step("b_rs1", 1'b1, mk(1,8,8,0,1,0,0,0,0,0, 0,0,1,0,0));
    memread_ex = 1'b0; rs_used_id = 1'b0;
    @(negedge clk);
    check("b_rs2.stall_before", b_stall, 1);
    rst = 1'b1;
    #1;
    check("b_rs.pc_write", b_pc_write, 1); check("b_rs.stall", b_stall, 0);
    check("b_rs.state", b_state, 0);       check("b_rs.stall_cycles", b_stall_cycles, 0);
    check("b_rs.a_stall_cycles", a_stall_cycles, 0);
    check("b_rs.a_flush_cycles", a_flush_cycles, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("b_rs_after1", 1'b1, idle_v);
    step("b_rs_after2", 1'b1, idle_v);

    // Single-cycle flush window on B.
    step("b_jmp", 1'b1, mk(0,0,0,0,0,0,0,0,0,1, 1,1,0,1,0));
    step("b_jmp_end", 1'b1, idle_v);
    check("b.flush_cycles_1", b_flush_cycles, 1);

    // Ten MDU stall cycles saturate the 3-bit counter at 7.
    step("b_sat0", 1'b1, mk(0,0,0,0,0,0,1,1,0,0, 0,0,1,0,0));
    for (int k = 1; k < 10; k++) begin
      step($sformatf("b_sat%0d", k), 1'b1, mk(0,0,0,0,0,0,1,1,0,0, 0,0,1,0,2));
    end
    check("b.stall_cycles_sat", b_stall_cycles, 7);
    step("b_sat_hold", 1'b1, mk(0,0,0,0,0,0,1,1,0,0, 0,0,1,0,2));
    check("b.stall_cycles_sat_hold", b_stall_cycles, 7);

    // Clear beats increment in a stalled cycle, then counting resumes.
    perf_clr = 1'b1;
    step("b_clr", 1'b1, mk(0,0,0,0,0,0,1,1,0,0, 0,0,1,0,2));
    perf_clr = 1'b0;
    check("b.stall_cycles_clr", b_stall_cycles, 0);
    check("b.flush_cycles_clr", b_flush_cycles, 0);
    step("b_after_clr", 1'b1, mk(0,0,0,0,0,0,1,1,0,0, 0,0,1,0,2));
    check("b.stall_cycles_resume", b_stall_cycles, 1);
    step("b_release", 1'b1, mk(0,0,0,0,0,0,1,0,0,0, 1,1,0,0,2));
    step("b_idle", 1'b1, idle_v);

    check("sb.empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
